// File: rtl/traffic_pkg.sv
// ============================================================================
// Module      : traffic_pkg
// Description : Lamp codes, scheduler state encoding and phase successor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package traffic_pkg;

    localparam logic [3:0] CAR_NONE   = 4'b0000;
    localparam logic [3:0] CAR_GREEN  = 4'b0001;
    localparam logic [3:0] CAR_LEFT   = 4'b0010;
    localparam logic [3:0] CAR_YELLOW = 4'b0100;
    localparam logic [3:0] CAR_RED    = 4'b1000;

    localparam logic [1:0] WALK_NONE  = 2'b00;
    localparam logic [1:0] WALK_GREEN = 2'b01;
    localparam logic [1:0] WALK_RED   = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_A_GRN    = 4'd1,
        ST_A_LFT    = 4'd2,
        ST_A_YEL    = 4'd3,
        ST_A_ALLRED = 4'd4,
        ST_B_GRN    = 4'd5,
        ST_B_LFT    = 4'd6,
        ST_B_YEL    = 4'd7,
        ST_B_ALLRED = 4'd8
    } state_e;

    function automatic state_e next_state(input state_e st);
        case (st)
            ST_A_GRN:    return ST_A_LFT;
            ST_A_LFT:    return ST_A_YEL;
            ST_A_YEL:    return ST_A_ALLRED;
            ST_A_ALLRED: return ST_B_GRN;
            ST_B_GRN:    return ST_B_LFT;
            ST_B_LFT:    return ST_B_YEL;
            ST_B_YEL:    return ST_B_ALLRED;
            default:     return ST_A_GRN;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/phase_timer.sv
// ============================================================================
// Module      : phase_timer
// Description : Per-state tick counter; done pulses on the final tick.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module phase_timer #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_i,
    input  logic          en_i,
    input  logic          tick_i,
    input  logic [CW:0]   dur_i,
    output logic          done_o,
    output logic [CW-1:0] count_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign done_o  = en_i && tick_i && ({1'b0, count_q} == (dur_i - (CW+1)'(1)));
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && tick_i) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/intersection_phase_scheduler.sv
// ============================================================================
// Module      : intersection_phase_scheduler
// Description : Two-group intersection phase FSM with lamp decode.
//               Build macro PED_REQ_EN enables on-demand walker service.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module intersection_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int GREEN_T  = 20,
    parameter int LEFT_T   = 2,
    parameter int YELLOW_T = 3,
    parameter int ALLRED_T = 2,
    parameter int BLINK_T  = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_start,
    input  logic       i_tick,
    input  logic       i_ped_req_a,
    input  logic       i_ped_req_b,
    output logic [3:0] o_e_ct,
    output logic [3:0] o_w_ct,
    output logic [3:0] o_s_ct,
    output logic [3:0] o_n_ct,
    output logic [1:0] o_e_wt,
    output logic [1:0] o_w_wt,
    output logic [1:0] o_s_wt,
    output logic [1:0] o_n_wt,
    output logic [3:0] o_phase,
    output logic       o_cycle_done
);

    localparam int MAX_GL  = (GREEN_T > LEFT_T) ? GREEN_T : LEFT_T;
    localparam int MAX_YA  = (YELLOW_T > ALLRED_T) ? YELLOW_T : ALLRED_T;
    localparam int MAX_D   = (MAX_GL > MAX_YA) ? MAX_GL : MAX_YA;
    localparam int CW      = (MAX_D > 1) ? $clog2(MAX_D) : 1;
    localparam int BSTART  = GREEN_T - BLINK_T;

    state_e        state_q;
    state_e        state_d;
    logic          cycle_done_q;
    logic          cycle_done_d;
    logic          run_en;
    logic          advance;
    logic          timer_done;
    logic [CW-1:0] timer_count;
    logic [CW:0]   dur;
    logic          serve_a;
    logic          serve_b;

    always_comb begin
        case (state_q)
            ST_A_GRN, ST_B_GRN:       dur = (CW+1)'(GREEN_T);
            ST_A_LFT, ST_B_LFT:       dur = (CW+1)'(LEFT_T);
            ST_A_YEL, ST_B_YEL:       dur = (CW+1)'(YELLOW_T);
            ST_A_ALLRED, ST_B_ALLRED: dur = (CW+1)'(ALLRED_T);
            default:                  dur = (CW+1)'(1);
        endcase
    end

    // A low i_start outside IDLE freezes counter and state together.
    assign run_en = i_start && (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        if (state_q == ST_IDLE) begin
            if (i_start) begin
                state_d = ST_A_GRN;
            end
        end else if (timer_done) begin
            state_d = next_state(state_q);
        end
    end

    assign advance      = (state_d != state_q);
    assign cycle_done_d = (state_q == ST_B_ALLRED) && timer_done;

    phase_timer #(
        .CW (CW)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear_i (advance),
        .en_i    (run_en),
        .tick_i  (i_tick),
        .dur_i   (dur),
        .done_o  (timer_done),
        .count_o (timer_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cycle_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cycle_done_q <= cycle_done_d;
        end
    end

`ifdef PED_REQ_EN
    logic req_a_q;
    logic req_b_q;
    logic serve_a_q;
    logic serve_b_q;

    // A request coinciding with the sampling edge re-arms the latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_a_q   <= 1'b0;
            req_b_q   <= 1'b0;
            serve_a_q <= 1'b0;
            serve_b_q <= 1'b0;
        end else begin
            if (advance && (state_d == ST_A_GRN)) begin
                serve_b_q <= req_b_q;
                req_b_q   <= i_ped_req_b;
            end else begin
                req_b_q   <= req_b_q | i_ped_req_b;
            end
            if (advance && (state_d == ST_B_GRN)) begin
                serve_a_q <= req_a_q;
                req_a_q   <= i_ped_req_a;
            end else begin
                req_a_q   <= req_a_q | i_ped_req_a;
            end
        end
    end

    assign serve_a = serve_a_q;
    assign serve_b = serve_b_q;
`else
    logic w_unused_req;

    assign w_unused_req = i_ped_req_a | i_ped_req_b;
    assign serve_a      = 1'b1;
    assign serve_b      = 1'b1;
`endif

    function automatic logic [1:0] walk_code(input logic serve, input logic [CW-1:0] cnt);
        logic [CW-1:0] rel;
        rel = cnt - CW'(BSTART);
        if (!serve) begin
            return WALK_RED;
        end
        if (cnt < CW'(BSTART)) begin
            return WALK_GREEN;
        end
        return rel[0] ? WALK_GREEN : WALK_NONE;
    endfunction

    always_comb begin
        o_e_ct = CAR_RED;
        o_w_ct = CAR_RED;
        o_s_ct = CAR_RED;
        o_n_ct = CAR_RED;
        o_e_wt = WALK_RED;
        o_w_wt = WALK_RED;
        o_s_wt = WALK_RED;
        o_n_wt = WALK_RED;
        case (state_q)
            ST_IDLE: begin
                o_e_ct = CAR_NONE;
                o_w_ct = CAR_NONE;
                o_s_ct = CAR_NONE;
                o_n_ct = CAR_NONE;
                o_e_wt = WALK_NONE;
                o_w_wt = WALK_NONE;
                o_s_wt = WALK_NONE;
                o_n_wt = WALK_NONE;
            end
            ST_A_GRN: begin
                o_e_ct = CAR_GREEN;
                o_w_ct = CAR_GREEN;
                o_s_wt = walk_code(serve_b, timer_count);
                o_n_wt = walk_code(serve_b, timer_count);
            end
            ST_A_LFT: begin
                o_e_ct = CAR_LEFT;
                o_w_ct = CAR_LEFT;
            end
            ST_A_YEL: begin
                o_e_ct = CAR_YELLOW;
                o_w_ct = CAR_YELLOW;
            end
            ST_B_GRN: begin
                o_s_ct = CAR_GREEN;
                o_n_ct = CAR_GREEN;
                o_e_wt = walk_code(serve_a, timer_count);
                o_w_wt = walk_code(serve_a, timer_count);
            end
            ST_B_LFT: begin
                o_s_ct = CAR_LEFT;
                o_n_ct = CAR_LEFT;
            end
            ST_B_YEL: begin
                o_s_ct = CAR_YELLOW;
                o_n_ct = CAR_YELLOW;
            end
            default: ;
        endcase
    end

    assign o_phase      = state_q;
    assign o_cycle_done = cycle_done_q;

endmodule

`default_nettype wire

// File: tb/tb_intersection_phase_scheduler.sv
// ============================================================================
// Module      : tb_intersection_phase_scheduler
// Description : Directed plus randomized check against a tick-position model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_intersection_phase_scheduler;

    localparam int G   = 20;
    localparam int L   = 2;
    localparam int Y   = 3;
    localparam int AR  = 2;
    localparam int BL  = 6;
    localparam int CYC = 2 * (G + L + Y + AR);

    logic       clk = 1'b0;
    logic       reset;
    logic       i_start;
    logic       i_tick;
    logic       i_ped_req_a;
    logic       i_ped_req_b;
    logic [3:0] o_e_ct, o_w_ct, o_s_ct, o_n_ct;
    logic [1:0] o_e_wt, o_w_wt, o_s_wt, o_n_wt;
    logic [3:0] o_phase;
    logic       o_cycle_done;

    int n_assert = 0;
    int n_fail   = 0;
    int cd_seen  = 0;

    // Model: position within the repeating cycle, measured in ticks.
    bit m_run = 1'b0;
    int m_t   = 0;
    bit m_cd  = 1'b0;
    bit m_la  = 1'b0;
    bit m_lb  = 1'b0;
    bit m_sa  = 1'b0;
    bit m_sb  = 1'b0;

    intersection_phase_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .i_start      (i_start),
        .i_tick       (i_tick),
        .i_ped_req_a  (i_ped_req_a),
        .i_ped_req_b  (i_ped_req_b),
        .o_e_ct       (o_e_ct),
        .o_w_ct       (o_w_ct),
        .o_s_ct       (o_s_ct),
        .o_n_ct       (o_n_ct),
        .o_e_wt       (o_e_wt),
        .o_w_wt       (o_w_wt),
        .o_s_wt       (o_s_wt),
        .o_n_wt       (o_n_wt),
        .o_phase      (o_phase),
        .o_cycle_done (o_cycle_done)
    );

    always #5 clk = ~clk;

    function automatic void decode(input int t, output int idx, output int off);
        int d[8];
        int acc;
        d   = '{G, L, Y, AR, G, L, Y, AR};
        acc = 0;
        idx = 7;
        off = 0;
        for (int i = 0; i < 8; i++) begin
            if (t < acc + d[i]) begin
                idx = i;
                off = t - acc;
                return;
            end
            acc += d[i];
        end
    endfunction

    function automatic int cur_idx();
        int idx, off;
        decode(m_t, idx, off);
        return m_run ? idx : -1;
    endfunction

    function automatic logic [3:0] kind_code(input int k);
        case (k)
            0:       return 4'b0001;
            1:       return 4'b0010;
            2:       return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic logic [1:0] walk(input bit serve, input int off);
        if (!serve)      return 2'b10;
        if (off < G - BL) return 2'b01;
        return (((off - (G - BL)) % 2) == 0) ? 2'b00 : 2'b01;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [15:0] e_car;
        logic [7:0]  e_walk;
        logic [3:0]  e_ph;
        logic [3:0]  ca, cb;
        logic [1:0]  wa, wb;
        int idx, off;
        if (!m_run) begin
            e_car  = '0;
            e_walk = '0;
            e_ph   = 4'd0;
        end else begin
            decode(m_t, idx, off);
            e_ph = 4'(idx + 1);
            ca   = (idx < 4) ? kind_code(idx % 4) : 4'b1000;
            cb   = (idx < 4) ? 4'b1000 : kind_code(idx % 4);
            wa   = (idx == 4) ? walk(m_sa, off) : 2'b10;
            wb   = (idx == 0) ? walk(m_sb, off) : 2'b10;
            e_car  = {ca, ca, cb, cb};
            e_walk = {wa, wa, wb, wb};
        end
        chk("car_lamps", {16'd0, o_e_ct, o_w_ct, o_s_ct, o_n_ct}, {16'd0, e_car});
        chk("walk_lamps", {24'd0, o_e_wt, o_w_wt, o_s_wt, o_n_wt}, {24'd0, e_walk});
        chk("phase", {28'd0, o_phase}, {28'd0, e_ph});
        chk("cycle_done", {31'd0, o_cycle_done}, {31'd0, m_cd});
    endtask

    task automatic model_edge();
        bit adv, ent_a, ent_b;
        if (reset) begin
            m_run = 1'b0;
            m_t   = 0;
            m_cd  = 1'b0;
            m_la  = 1'b0;
            m_lb  = 1'b0;
            m_sa  = 1'b0;
            m_sb  = 1'b0;
        end else begin
            adv   = m_run && i_start && i_tick;
            ent_a = (!m_run && i_start) || (adv && m_t == CYC - 1);
            ent_b = adv && (m_t == CYC / 2 - 1);
`ifdef PED_REQ_EN
            if (ent_a) begin
                m_sb = m_lb;
                m_lb = i_ped_req_b;
            end else begin
                m_lb = m_lb | i_ped_req_b;
            end
            if (ent_b) begin
                m_sa = m_la;
                m_la = i_ped_req_a;
            end else begin
                m_la = m_la | i_ped_req_a;
            end
`else
            m_sa = 1'b1;
            m_sb = 1'b1;
`endif
            m_cd = adv && (m_t == CYC - 1);
            if (!m_run) begin
                if (i_start) begin
                    m_run = 1'b1;
                    m_t   = 0;
                end
            end else if (adv) begin
                m_t = (m_t + 1) % CYC;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        if (o_cycle_done) cd_seen++;
    endtask

    task automatic wait_phase(input int k, input string tag);
        int i;
        i = 0;
        while (cur_idx() != k && i < 3000) begin
            i_tick = ($urandom % 3 == 0);
            step();
            i++;
        end
        i_tick = 1'b0;
        chk(tag, {31'd0, (cur_idx() == k)}, 32'd1);
    endtask

    initial begin
        int cd0;
        logic [3:0] hold_ct;
        logic [3:0] hold_ph;
        reset       = 1'b1;
        i_start     = 1'b0;
        i_tick      = 1'b0;
        i_ped_req_a = 1'b0;
        i_ped_req_b = 1'b0;
        repeat (3) step();
        chk("reset_phase", {28'd0, o_phase}, 32'd0);
        reset = 1'b0;
        repeat (2) step();

        // Start, then one tick every 10 clk for two full cycles.
        i_start = 1'b1;
        step();
        chk("start_latency", {28'd0, o_phase}, 32'd1);
        chk("start_ew_green", {28'd0, o_e_ct}, 32'd1);
        cd0 = cd_seen;
        for (int k = 1; k <= 2 * CYC; k++) begin
            repeat (9) step();
            i_tick = 1'b1;
            step();
            i_tick = 1'b0;
            if (k == G) chk("adv_to_left", {28'd0, o_phase}, 32'd2);
        end
        chk("cycle_done_count", 32'(cd_seen - cd0), 32'd2);

        // Randomized traffic with occasional stalls and requests.
        for (int n = 0; n < 4000; n++) begin
            i_tick      = ($urandom % 3 == 0);
            i_start     = ($urandom % 20 != 0);
            i_ped_req_a = ($urandom % 40 == 0);
            i_ped_req_b = ($urandom % 40 == 0);
            step();
        end
        i_start     = 1'b1;
        i_ped_req_a = 1'b0;
        i_ped_req_b = 1'b0;

        // Freeze for 100 clk in A_YEL.
        wait_phase(2, "reach_a_yel");
        hold_ct = o_e_ct;
        hold_ph = o_phase;
        i_start = 1'b0;
        for (int n = 0; n < 100; n++) begin
            i_tick = ($urandom % 2 == 0);
            step();
        end
        chk("freeze_ct", {28'd0, o_e_ct}, {28'd0, hold_ct});
        chk("freeze_phase", {28'd0, o_phase}, {28'd0, hold_ph});
        i_start = 1'b1;
        wait_phase(3, "yel_completes");

        // Reset in B_GRN.
        wait_phase(4, "reach_b_grn");
        reset = 1'b1;
        step();
        chk("rst_mid_phase", {28'd0, o_phase}, 32'd0);
        chk("rst_mid_cars", {16'd0, o_e_ct, o_w_ct, o_s_ct, o_n_ct}, 32'd0);
        chk("rst_mid_walk", {24'd0, o_e_wt, o_w_wt, o_s_wt, o_n_wt}, 32'd0);
        reset = 1'b0;
        step();

`ifdef PED_REQ_EN
        // No requests: a full cycle keeps every walker red.
        i_start = 1'b1;
        for (int n = 0; n < 2 * CYC; n++) begin
            i_tick = n[0];
            step();
            if (m_run) chk("ped_idle_walk", {24'd0, o_e_wt, o_w_wt, o_s_wt, o_n_wt}, 32'hAA);
        end
        i_tick = 1'b0;
        wait_phase(4, "ped_reach_b_grn");
        i_ped_req_b = 1'b1;
        step();
        i_ped_req_b = 1'b0;
        wait_phase(0, "ped_reach_a_grn");
        chk("ped_served_sn", {30'd0, o_s_wt}, 32'd1);
        // Pulse a request on the edge that enters A_GRN.
        wait_phase(7, "ped_reach_b_allred");
        while (m_t != CYC - 1) begin
            i_tick = 1'b1;
            step();
        end
        i_tick      = 1'b1;
        i_ped_req_b = 1'b1;
        step();
        i_tick      = 1'b0;
        i_ped_req_b = 1'b0;
        chk("ped_entry_unserved", {30'd0, o_s_wt}, 32'd2);
        wait_phase(4, "ped_next_b");
        wait_phase(0, "ped_next_a");
        chk("ped_entry_served_next", {30'd0, o_s_wt}, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
